// File: rtl/gen_sample_fifo.sv
// Sample FIFO between the function generator and its downstream reader.
// Separate occupancy counter, registered read data, sticky overflow/underflow flags.
module gen_sample_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en_i,
   input  logic [DATA_WIDTH-1:0]      data_i,
   input  logic                       rd_en_i,
   output logic [DATA_WIDTH-1:0]      data_o,
   output logic                       rd_valid_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       almost_full_o,
   output logic                       almost_empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o,
   output logic                       underflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  rd_valid_q;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  rd_acc, wr_acc;

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   always_comb begin
      rd_acc      = rd_en_i && (count_q != '0);
      wr_acc      = wr_en_i && ((count_q < CW'(DEPTH)) || rd_acc);
      wr_ptr_d    = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d    = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
      overflow_d  = overflow_q  || (wr_en_i && !wr_acc);
      underflow_d = underflow_q || (rd_en_i && (count_q == '0));
   end

   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_q      <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_valid_q  <= rd_acc;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         if (rd_acc) begin
            data_q <= mem[rd_ptr_q];
         end
      end
   end

   assign data_o         = data_q;
   assign rd_valid_o     = rd_valid_q;
   assign count_o        = count_q;
   assign full_o         = (count_q == CW'(DEPTH));
   assign empty_o        = (count_q == '0);
   assign almost_full_o  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty_o = (count_q <= CW'(AE_LEVEL));
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_gen_sample_fifo.sv
// Directed bench for gen_sample_fifo: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_gen_sample_fifo;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [DW-1:0] din;
   logic          rd_en;
   logic [DW-1:0] dout;
   logic          rd_valid, full, empty, afull, aempty, ovf, udf;
   logic [4:0]    count;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   gen_sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk            (clk),
      .rst            (rst),
      .wr_en_i        (wr_en),
      .data_i         (din),
      .rd_en_i        (rd_en),
      .data_o         (dout),
      .rd_valid_o     (rd_valid),
      .full_o         (full),
      .empty_o        (empty),
      .almost_full_o  (afull),
      .almost_empty_o (aempty),
      .count_o        (count),
      .overflow_o     (ovf),
      .underflow_o    (udf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue plus the observable registers.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_data;
   bit            m_valid, m_ovf, m_udf;

   always @(posedge clk) begin
      int  sz;
      bit  rd_ok, wr_ok;
      sz = mq.size();
      if (rst) begin
         mq.delete();
         m_data  = '0;
         m_valid = 0;
         m_ovf   = 0;
         m_udf   = 0;
      end else begin
         rd_ok   = rd_en && (sz > 0);
         wr_ok   = wr_en && ((sz < DEPTH) || rd_ok);
         m_valid = rd_ok;
         if (rd_ok) m_data = mq.pop_front();
         if (wr_ok) mq.push_back(din);
         if (wr_en && !wr_ok) m_ovf = 1;
         if (rd_en && sz == 0) m_udf = 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         int sz;
         sz = mq.size();
         chk("m_count",  32'(count),    32'(sz));
         chk("m_full",   32'(full),     32'(sz == DEPTH));
         chk("m_empty",  32'(empty),    32'(sz == 0));
         chk("m_afull",  32'(afull),    32'(sz >= AF));
         chk("m_aempty", 32'(aempty),   32'(sz <= AE));
         chk("m_valid",  32'(rd_valid), 32'(m_valid));
         chk("m_data",   32'(dout),     32'(m_data));
         chk("m_ovf",    32'(ovf),      32'(m_ovf));
         chk("m_udf",    32'(udf),      32'(m_udf));
      end
   end

   // Apply one cycle of inputs; returns at the following falling edge.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
      wr_en = w;
      din   = d;
      rd_en = r;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; din = '0; rd_en = 1'b0;

      // 1. reset then idle
      step(0, 0, 0);
      step(0, 0, 0);
      rst = 1'b0;
      chk_en = 1;
      step(0, 0, 0);
      chk("t1_empty",  32'(empty),    32'd1);
      chk("t1_aempty", 32'(aempty),   32'd1);
      chk("t1_count",  32'(count),    32'd0);
      chk("t1_data",   32'(dout),     32'd0);
      chk("t1_valid",  32'(rd_valid), 32'd0);
      chk("t1_ovf",    32'(ovf),      32'd0);
      chk("t1_udf",    32'(udf),      32'd0);

      // 2. fill and drain
      for (int i = 1; i <= 16; i++) begin
         step(1, DW'(i), 0);
         if (i == 11) chk("t2_afull_11", 32'(afull), 32'd0);
         if (i == 12) chk("t2_afull_12", 32'(afull), 32'd1);
         if (i == 15) chk("t2_full_15",  32'(full),  32'd0);
      end
      chk("t2_full",  32'(full),  32'd1);
      chk("t2_count", 32'(count), 32'd16);
      for (int i = 1; i <= 16; i++) begin
         step(0, 0, 1);
         chk("t2_rdata",  32'(dout),     32'(i));
         chk("t2_rvalid", 32'(rd_valid), 32'd1);
      end
      step(0, 0, 0);
      chk("t2_empty", 32'(empty),    32'd1);
      chk("t2_idle",  32'(rd_valid), 32'd0);

      // 3. overflow
      for (int i = 0; i < 16; i++) step(1, DW'(16'h0100 + i), 0);
      step(1, 16'h7FFF, 0);
      chk("t3_ovf",   32'(ovf),   32'd1);
      chk("t3_count", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 1);
         chk("t3_rdata", 32'(dout), 32'(16'h0100 + i));
      end
      chk("t3_ovf_hold", 32'(ovf), 32'd1);

      // 4. underflow with simultaneous write on empty
      step(1, 16'h8000, 1);
      chk("t4_udf",   32'(udf),      32'd1);
      chk("t4_count", 32'(count),    32'd1);
      chk("t4_valid", 32'(rd_valid), 32'd0);
      step(0, 0, 1);
      chk("t4_rdata",  32'(dout),     32'h8000);
      chk("t4_rvalid", 32'(rd_valid), 32'd1);

      // 5. full simultaneous read/write across pointer wrap
      rst = 1'b1;
      step(0, 0, 0);
      rst = 1'b0;
      chk("t5_rst_ovf", 32'(ovf), 32'd0);
      for (int i = 0; i < 16; i++) step(1, DW'(16'h0200 + i), 0);
      for (int k = 0; k < 20; k++) begin
         step(1, DW'(16'h0300 + k), 1);
         chk("t5_count", 32'(count), 32'd16);
         chk("t5_full",  32'(full),  32'd1);
         chk("t5_ovf",   32'(ovf),   32'd0);
         chk("t5_rdata", 32'(dout),  (k < 16) ? 32'(16'h0200 + k) : 32'(16'h0300 + k - 16));
      end
      for (int k = 4; k < 20; k++) begin
         step(0, 0, 1);
         chk("t5_drain", 32'(dout), 32'(16'h0300 + k));
      end

      // 6. reset mid-operation
      step(0, 0, 1);
      chk("t6_udf_set", 32'(udf), 32'd1);
      for (int i = 0; i < 7; i++) step(1, DW'(16'h0400 + i), 0);
      chk("t6_count7", 32'(count), 32'd7);
      rst = 1'b1;
      step(0, 0, 0);
      rst = 1'b0;
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_empty", 32'(empty), 32'd1);
      chk("t6_ovf",   32'(ovf),   32'd0);
      chk("t6_udf",   32'(udf),   32'd0);
      step(1, 16'h1234, 0);
      step(0, 0, 1);
      chk("t6_rdata",  32'(dout),     32'h1234);
      chk("t6_rvalid", 32'(rd_valid), 32'd1);
      step(0, 0, 0);

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
